// File: rtl/dcmac_link_ctrl.sv
// dcmac_link_ctrl: reset/bring-up sequencer for the 2-port DCMAC + GT quad, per-port link retry
module dcmac_link_ctrl #(
  parameter int NPORT           = 2,
  parameter int RESET_CYCLES    = 256,
  parameter int RX_RESET_CYCLES = 32,
  parameter int DONE_TIMEOUT    = 1048576,
  parameter int ALIGN_TIMEOUT   = 4194304,
  parameter int BLANK_CYCLES    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               gtpowergood,
  input  logic [NPORT-1:0]   gt_tx_reset_done,
  input  logic [NPORT-1:0]   gt_rx_reset_done,
  input  logic [NPORT-1:0]   rx_aligned,
  output logic               user_gt_reset_all,
  output logic [NPORT-1:0]   user_gt_reset_rx_datapath,
  output logic [NPORT-1:0]   link_up,
  output logic               init_done,
  output logic [1:0]         state,
  output logic [3:0]         global_retries,
  output logic [4*NPORT-1:0] port_retries
);
  localparam int TMAX_A = DONE_TIMEOUT > ALIGN_TIMEOUT ? DONE_TIMEOUT : ALIGN_TIMEOUT;
  localparam int TMAX_B = RESET_CYCLES > RX_RESET_CYCLES ? RESET_CYCLES : RX_RESET_CYCLES;
  localparam int TMAX   = TMAX_A > TMAX_B ? TMAX_A : TMAX_B;
  localparam int TW     = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_RESET = TW'(RESET_CYCLES);
  localparam logic [TW-1:0] T_RX    = TW'(RX_RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_DONE  = TW'(DONE_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ALIGN = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [TW-1:0] T_BLANK = TW'(BLANK_CYCLES);

  typedef enum logic [1:0] {WAIT_PGOOD = 2'd0, RESET_ALL = 2'd1, WAIT_DONE = 2'd2, RUN = 2'd3} top_t;
  typedef enum logic [2:0] {P_IDLE, P_WAIT_ALIGN, P_RX_RESET, P_WAIT_RDONE, P_UP} port_t;

  top_t            st;
  logic [TW-1:0]   tmr;
  logic [1:0]      pg_q;
  logic [NPORT-1:0] al_q, aligned_s;
  logic            pgood_s, pg_drop, do_restart, run_en;

  assign pgood_s    = pg_q[1];
  assign pg_drop    = !pgood_s && st != WAIT_PGOOD;
  assign do_restart = restart && !pg_drop;
  assign run_en     = st == RUN && !pg_drop && !do_restart;
  assign state      = st;

  // two-flop synchronizers for the asynchronous power-good and alignment inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pg_q      <= '0;
      al_q      <= '0;
      aligned_s <= '0;
    end else begin
      pg_q      <= {pg_q[0], gtpowergood};
      al_q      <= rx_aligned;
      aligned_s <= al_q;
    end
  end

  // top FSM: power-good loss beats restart, restart beats normal sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st                <= WAIT_PGOOD;
      tmr               <= '0;
      user_gt_reset_all <= 1'b1;
      init_done         <= 1'b0;
      global_retries    <= '0;
    end else if (pg_drop) begin
      st                <= WAIT_PGOOD;
      user_gt_reset_all <= 1'b1;
      init_done         <= 1'b0;
    end else if (restart) begin
      st                <= RESET_ALL;
      tmr               <= T_RESET;
      user_gt_reset_all <= 1'b1;
      init_done         <= 1'b0;
      global_retries    <= '0;
    end else begin
      case (st)
        WAIT_PGOOD: if (pgood_s) begin
          st  <= RESET_ALL;
          tmr <= T_RESET;
        end
        RESET_ALL: if (tmr == T_ONE) begin
          st                <= WAIT_DONE;
          tmr               <= '0;
          user_gt_reset_all <= 1'b0;
        end else tmr <= tmr - T_ONE;
        WAIT_DONE: if (tmr >= T_BLANK && &gt_tx_reset_done && &gt_rx_reset_done) begin
          st        <= RUN;
          init_done <= 1'b1;
        end else if (tmr == T_DONE) begin
          st                <= RESET_ALL;
          tmr               <= T_RESET;
          user_gt_reset_all <= 1'b1;
          global_retries    <= global_retries + {3'd0, global_retries != 4'hf};
        end else tmr <= tmr + T_ONE;
        default: ;
      endcase
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    port_t         ps;
    logic [TW-1:0] pt;
    logic [3:0]    pr;
    logic          lu, rr;

    assign link_up[p]                   = lu;
    assign user_gt_reset_rx_datapath[p] = rr;
    assign port_retries[4*p +: 4]       = pr;

    // per-port FSM: held idle outside RUN, retries rx datapath reset until aligned
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ps <= P_IDLE;
        pt <= '0;
        pr <= '0;
        lu <= 1'b0;
        rr <= 1'b0;
      end else if (!run_en) begin
        ps <= P_IDLE;
        lu <= 1'b0;
        rr <= 1'b0;
        if (do_restart) pr <= '0;
      end else begin
        case (ps)
          P_IDLE: begin
            ps <= P_WAIT_ALIGN;
            pt <= '0;
          end
          P_WAIT_ALIGN: if (aligned_s[p]) begin
            ps <= P_UP;
            lu <= 1'b1;
          end else if (pt == T_ALIGN) begin
            ps <= P_RX_RESET;
            pt <= '0;
            rr <= 1'b1;
            pr <= pr + {3'd0, pr != 4'hf};
          end else pt <= pt + T_ONE;
          P_RX_RESET: if (pt == T_RX) begin
            ps <= P_WAIT_RDONE;
            pt <= '0;
            rr <= 1'b0;
          end else pt <= pt + T_ONE;
          P_WAIT_RDONE: if (pt >= T_BLANK && gt_rx_reset_done[p]) begin
            ps <= P_WAIT_ALIGN;
            pt <= '0;
          end else if (pt == T_DONE) begin
            ps <= P_RX_RESET;
            pt <= '0;
            rr <= 1'b1;
            pr <= pr + {3'd0, pr != 4'hf};
          end else pt <= pt + T_ONE;
          P_UP: if (!gt_rx_reset_done[p]) begin
            ps <= P_WAIT_RDONE;
            pt <= '0;
            lu <= 1'b0;
          end else if (!aligned_s[p]) begin
            ps <= P_WAIT_ALIGN;
            pt <= '0;
            lu <= 1'b0;
          end
          default: ps <= P_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dcmac_link_ctrl.sv
// tb_dcmac_link_ctrl: directed vector table plus hand-written multi-cycle sequences
module tb_dcmac_link_ctrl;
  logic       clk = 1'b0, reset = 1'b1, restart = 1'b0, gtpowergood = 1'b1;
  logic [1:0] gt_tx_reset_done = '0, gt_rx_reset_done = '0, rx_aligned = '0;
  logic       user_gt_reset_all, init_done;
  logic [1:0] user_gt_reset_rx_datapath, link_up, state;
  logic [3:0] global_retries;
  logic [7:0] port_retries;
  int         pass = 0, total = 0;

  dcmac_link_ctrl #(
    .NPORT(2), .RESET_CYCLES(8), .RX_RESET_CYCLES(4), .DONE_TIMEOUT(64),
    .ALIGN_TIMEOUT(32), .BLANK_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .gtpowergood(gtpowergood),
    .gt_tx_reset_done(gt_tx_reset_done), .gt_rx_reset_done(gt_rx_reset_done),
    .rx_aligned(rx_aligned), .user_gt_reset_all(user_gt_reset_all),
    .user_gt_reset_rx_datapath(user_gt_reset_rx_datapath), .link_up(link_up),
    .init_done(init_done), .state(state), .global_retries(global_retries),
    .port_retries(port_retries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pg; logic [1:0] tx, rx, al; logic rs; int cyc;
    logic [1:0] st; logic ra, ini; logic [1:0] lu, rr; logic [7:0] pr; logic [3:0] gr;
  } vec_t;

  vec_t v[25];

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_st(logic [1:0] s, int bound, string nm);
    int i = 0;
    while (state !== s && i < bound) begin
      tick(1);
      i++;
    end
    chk(nm, {30'd0, state}, {30'd0, s});
  endtask

  function automatic logic [19:0] outs();
    return {state, user_gt_reset_all, init_done, link_up, user_gt_reset_rx_datapath,
            port_retries, global_retries};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, wt, w;
    logic p0_bad;
    v[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0,  2, 2'd0, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[1]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0,  1, 2'd1, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[2]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0,  7, 2'd1, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[3]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0,  1, 2'd2, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[4]  = '{1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 20, 2'd3, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 4'd0};
    v[5]  = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  2, 2'd3, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 4'd0};
    v[6]  = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  1, 2'd3, 1'b0, 1'b1, 2'b11, 2'b00, 8'h00, 4'd0};
    v[7]  = '{1'b1, 2'b11, 2'b11, 2'b01, 1'b0,  3, 2'd3, 1'b0, 1'b1, 2'b01, 2'b00, 8'h00, 4'd0};
    v[8]  = '{1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 20, 2'd3, 1'b0, 1'b1, 2'b01, 2'b00, 8'h00, 4'd0};
    v[9]  = '{1'b1, 2'b11, 2'b11, 2'b01, 1'b0, 11, 2'd3, 1'b0, 1'b1, 2'b01, 2'b00, 8'h00, 4'd0};
    v[10] = '{1'b1, 2'b11, 2'b11, 2'b01, 1'b0,  1, 2'd3, 1'b0, 1'b1, 2'b01, 2'b10, 8'h10, 4'd0};
    v[11] = '{1'b1, 2'b11, 2'b11, 2'b01, 1'b0,  3, 2'd3, 1'b0, 1'b1, 2'b01, 2'b10, 8'h10, 4'd0};
    v[12] = '{1'b1, 2'b11, 2'b11, 2'b01, 1'b0,  1, 2'd3, 1'b0, 1'b1, 2'b01, 2'b00, 8'h10, 4'd0};
    v[13] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0, 10, 2'd3, 1'b0, 1'b1, 2'b11, 2'b00, 8'h10, 4'd0};
    v[14] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b1,  1, 2'd1, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[15] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  7, 2'd1, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[16] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  1, 2'd2, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[17] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  4, 2'd2, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[18] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  1, 2'd3, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 4'd0};
    v[19] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  1, 2'd3, 1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 4'd0};
    v[20] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  1, 2'd3, 1'b0, 1'b1, 2'b11, 2'b00, 8'h00, 4'd0};
    v[21] = '{1'b0, 2'b11, 2'b11, 2'b11, 1'b0,  2, 2'd3, 1'b0, 1'b1, 2'b11, 2'b00, 8'h00, 4'd0};
    v[22] = '{1'b0, 2'b11, 2'b11, 2'b11, 1'b0,  1, 2'd0, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[23] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  2, 2'd0, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};
    v[24] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0,  1, 2'd1, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0};

    tick(2);
    chk("reset_values", {12'd0, outs()}, {12'd0, 2'd0, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0});
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      gtpowergood      = v[i].pg;
      gt_tx_reset_done = v[i].tx;
      gt_rx_reset_done = v[i].rx;
      rx_aligned       = v[i].al;
      restart          = v[i].rs;
      tick(v[i].cyc);
      chk($sformatf("row%0d", i), {12'd0, outs()},
          {12'd0, v[i].st, v[i].ra, v[i].ini, v[i].lu, v[i].rr, v[i].pr, v[i].gr});
    end
    restart = 1'b0;

    gt_rx_reset_done = 2'b01;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      wait_st(2'd2, 100, $sformatf("enter_wait_done%0d", k));
      cnt = 0;
      while (state === 2'd2 && cnt < 200) begin
        tick(1);
        cnt++;
      end
      chk($sformatf("done_timeout_len%0d", k), cnt, 64);
      chk($sformatf("global_retries%0d", k), {28'd0, global_retries}, k > 15 ? 15 : k);
    end

    gt_rx_reset_done = 2'b11;
    rx_aligned = 2'b01;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    wait_st(2'd3, 100, "run_align_retry");
    tick(3);
    chk("port0_up", {30'd0, link_up}, 32'd1);
    p0_bad = 1'b0;
    w = 0;
    for (int k = 1; k <= 3; k++) begin
      wt = 0;
      while (!user_gt_reset_rx_datapath[1] && wt < 100) begin
        tick(1);
        wt++;
        if (link_up[0] !== 1'b1 || user_gt_reset_rx_datapath[0] !== 1'b0) p0_bad = 1'b1;
      end
      chk($sformatf("port1_retries%0d", k), {28'd0, port_retries[7:4]}, k);
      if (k > 1) chk($sformatf("port1_period%0d", k), w + wt, 41);
      w = 0;
      while (user_gt_reset_rx_datapath[1] && w < 20) begin
        tick(1);
        w++;
        if (link_up[0] !== 1'b1 || user_gt_reset_rx_datapath[0] !== 1'b0) p0_bad = 1'b1;
      end
      chk($sformatf("port1_pulse_width%0d", k), w, 4);
    end
    chk("port0_undisturbed", {27'd0, p0_bad, port_retries[3:0]}, 32'd0);

    gtpowergood = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("pgood_beats_restart", {18'd0, state, user_gt_reset_all, init_done, link_up, port_retries},
        {18'd0, 2'd0, 1'b1, 1'b0, 2'b00, 8'h30});

    gtpowergood = 1'b1;
    wait_st(2'd3, 100, "run_after_pgood");
    wt = 0;
    while (!user_gt_reset_rx_datapath[1] && wt < 100) begin
      tick(1);
      wt++;
    end
    chk("reach_rx_reset", {31'd0, user_gt_reset_rx_datapath[1]}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset", {12'd0, outs()}, {12'd0, 2'd0, 1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 4'd0});
    tick(2);
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
